vector_list_sequencer: RTL and testbench
========================================

Name: vector_list_sequencer

Overview:
Frame-level scheduler for the vector control datapath. Fetches a display list of 32-bit command words from a synchronous-read RAM, decodes JUMP/DRAW/END/NOP, and issues one-cycle jump/draw strobes with x/y coordinates to the DAC/line-generator controller, honouring its ready handshake. Repeats the list every frame, enforces a minimum frame period, and swaps between two list banks only at frame boundaries.

Parameters:
ADDR_W, 10, word address width per bank; the RAM address is {bank, ADDR_W bits}.
MIN_FRAME_CYCLES, 50000, minimum clk cycles from frame start to the next frame start.
SETTLE_CYCLES, 2, cycles after a strobe during which ready is ignored (covers controller strobe latency).
CNT_W, 16, width of the frame timer; must hold MIN_FRAME_CYCLES.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  run frames; sampled at frame boundaries only
bank_sel  in  1  requested list bank; latched at frame start
mem_addr  out  ADDR_W+1  RAM address {bank, word}
mem_rd  out  1  read enable; data valid exactly 1 cycle later
mem_data  in  32  [31:30] op (00 JUMP, 01 DRAW, 10 END, 11 NOP), [29:24] reserved, [23:12] x, [11:0] y
x  out  12  coordinate, held stable from strobe until the next strobe
y  out  12  coordinate, as x
jump  out  1  one-cycle jump strobe
draw  out  1  one-cycle draw strobe
ready  in  1  controller ready
frame_done  out  1  one-cycle pulse when END is reached (or on overrun)
active_bank  out  1  bank of the current frame
busy  out  1  high in every state except IDLE and FRAME_WAIT
overrun  out  1  sticky: list ran past the last address without an END; cleared by reset only

Behaviour:
- Reset: state IDLE; all outputs 0; word pointer 0; timer 0. Reset mid-frame aborts with no further strobes.
- IDLE: if enable, latch bank_sel into active_bank, clear the timer and go to FETCH; otherwise stay.
- FETCH: mem_rd=1, mem_addr={active_bank, ptr}; go to WAIT_DATA.
- WAIT_DATA: capture mem_data into a command register; go to DECODE.
- DECODE:
  - NOP: ptr+1, go to FETCH.
  - END: frame_done pulse, go to FRAME_WAIT.
  - JUMP or DRAW: go to WAIT_READY.
- WAIT_READY: when ready=1, drive x/y from the command and assert the matching strobe for exactly 1 cycle in that same cycle (x/y and strobe are registered together). ptr+1, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE: count down, ignoring ready; at 0 go to FETCH. The next command's fetch overlaps the controller's work; the strobe still waits for ready.
- Pointer wrap: incrementing from 2^ADDR_W-1 sets overrun, pulses frame_done and goes to FRAME_WAIT (treated as END).
- FRAME_WAIT: ptr=0. When timer >= MIN_FRAME_CYCLES-1 and ready=1: if enable, latch bank_sel and go to FETCH with the timer cleared; otherwise go to IDLE.
- Frame timer: counts every cycle from frame start and saturates at all-ones; never wraps.
- A frame that runs longer than MIN_FRAME_CYCLES restarts as soon as END is reached and ready=1.
- jump and draw are never high in the same cycle. At most one strobe per command.
- bank_sel and enable changes mid-frame have no effect until the frame boundary.

Decomposition:
- Shared package vector_pkg:
  - opcode constants OP_JUMP, OP_DRAW, OP_END, OP_NOP
  - field position constants for op/x/y
  - state enum typedef
  - COORD_W=12
- Sub-module: vector_frame_timer (saturating counter with clear and an elapsed flag). Everything else stays flat.

Test Plan:
1. Bank0 = JUMP(100,200), DRAW(300,400), END; ready tied 1; MIN_FRAME_CYCLES=64 -> jump with x=100,y=200, then draw with x=300,y=400 at least SETTLE+3 cycles later; frame_done 1 cycle; the next frame's first fetch occurs 64 cycles after the previous frame start.
2. Same list; ready held 0 for 20 cycles after the jump -> draw is delayed until the first cycle ready=1, with no duplicate strobes.
3. NOP,NOP,DRAW(4095,0),END -> exactly one draw, x=4095,y=0; mem_addr sequence 0,1,2,3.
4. Bank0 = END only, bank1 = JUMP(1,1),END; toggle bank_sel mid-frame -> the switch takes effect only after frame_done; active_bank changes at the frame start; the bank1 jump appears.
5. ADDR_W=3, no END in 8 words of DRAW -> 8 draws, overrun=1 and sticky, frame_done pulses, the next frame restarts at address 0.
6. Assert reset during SETTLE of the second command -> the next cycle all outputs are 0 and state is IDLE; with enable=1 the frame restarts from address 0.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the vector list sequencer: command word layout,
// opcodes, coordinate width and the sequencer state encoding.
package vector_pkg;

  localparam int COORD_W = 12;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;
  localparam int X_MSB  = 23;
  localparam int X_LSB  = 12;
  localparam int Y_MSB  = 11;
  localparam int Y_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_DECODE     = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_SETTLE     = 3'd5,
    ST_FRAME_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/vector_frame_timer.sv
// Saturating frame timer. Cleared at every frame start; elapsed is high once
// the minimum frame period has been served (the frame may restart next edge).
module vector_frame_timer #(
  parameter int CNT_W            = 16,
  parameter int MIN_FRAME_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic elapsed
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MIN_FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count every cycle, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign elapsed = (count >= LIMIT);

endmodule

// File: rtl/vector_list_sequencer.sv
// Frame-level display-list sequencer: walks a bank of command words in RAM,
// issues jump/draw strobes with coordinates under the controller's ready
// handshake, and repeats the list no faster than the minimum frame period.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_W           = 10,
  parameter int MIN_FRAME_CYCLES = 50000,
  parameter int SETTLE_CYCLES    = 2,
  parameter int CNT_W            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               bank_sel,
  output logic [ADDR_W:0]    mem_addr,
  output logic               mem_rd,
  input  logic [31:0]        mem_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  input  logic               ready,
  output logic               frame_done,
  output logic               active_bank,
  output logic               busy,
  output logic               overrun
);

  localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t               state;
  // One extra bit catches the increment past the last word of the bank.
  logic [ADDR_W:0]      ptr;
  logic [1:0]           cmd_op;
  logic [COORD_W-1:0]   cmd_x;
  logic [COORD_W-1:0]   cmd_y;
  logic [SET_W-1:0]     settle_cnt;
  logic                 timer_clear;
  logic                 elapsed;
  logic                 unused_reserved;

  assign unused_reserved = ^mem_data[29:24];

  vector_frame_timer #(
    .CNT_W            (CNT_W),
    .MIN_FRAME_CYCLES (MIN_FRAME_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .elapsed (elapsed)
  );

  assign mem_rd   = (state == ST_FETCH) && !ptr[ADDR_W];
  assign mem_addr = {active_bank, ptr[ADDR_W-1:0]};
  assign busy     = (state != ST_IDLE) && (state != ST_FRAME_WAIT);

  // Restart the frame timer on the cycle that launches a new frame.
  always_comb begin
    timer_clear = 1'b0;
    if (state == ST_IDLE && enable) begin
      timer_clear = 1'b1;
    end
    if (state == ST_FRAME_WAIT && elapsed && ready && enable) begin
      timer_clear = 1'b1;
    end
  end

  // Sequencer FSM: fetch, decode and issue commands; strobes are single-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      settle_cnt  <= '0;
      x           <= '0;
      y           <= '0;
      jump        <= 1'b0;
      draw        <= 1'b0;
      frame_done  <= 1'b0;
      active_bank <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      jump       <= 1'b0;
      draw       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            active_bank <= bank_sel;
            ptr         <= '0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ptr[ADDR_W]) begin
            // Ran off the end of the bank without an END: close the frame.
            overrun    <= 1'b1;
            frame_done <= 1'b1;
            ptr        <= '0;
            state      <= ST_FRAME_WAIT;
          end else begin
            state <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          cmd_op <= mem_data[OP_MSB:OP_LSB];
          cmd_x  <= mem_data[X_MSB:X_LSB];
          cmd_y  <= mem_data[Y_MSB:Y_LSB];
          state  <= ST_DECODE;
        end
        ST_DECODE: begin
          case (cmd_op)
            OP_NOP: begin
              ptr   <= ptr + 1'b1;
              state <= ST_FETCH;
            end
            OP_END: begin
              frame_done <= 1'b1;
              ptr        <= '0;
              state      <= ST_FRAME_WAIT;
            end
            default: state <= ST_WAIT_READY;
          endcase
        end
        ST_WAIT_READY: begin
          if (ready) begin
            x          <= cmd_x;
            y          <= cmd_y;
            jump       <= (cmd_op == OP_JUMP);
            draw       <= (cmd_op == OP_DRAW);
            ptr        <= ptr + 1'b1;
            settle_cnt <= SET_W'(SETTLE_CYCLES);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Ready is stale while the controller reacts to the strobe.
          if (settle_cnt == '0) begin
            state <= ST_FETCH;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_FRAME_WAIT: begin
          ptr <= '0;
          if (elapsed && ready) begin
            if (enable) begin
              active_bank <= bank_sel;
              state       <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Self-checking bench for vector_list_sequencer: table-driven lists, hand
// sequences for timing/bank/overrun/reset corners, and random lists checked
// against a list-walking reference model.
module tb_vector_list_sequencer;

  localparam int ADDR_W    = 3;
  localparam int MIN_FRAME = 64;
  localparam int SETTLE    = 2;
  localparam int CNT_W     = 16;
  localparam logic [31:0] E_CMD = 32'h8000_0000;
  localparam logic [31:0] N_CMD = 32'hC000_0000;

  logic              clk, reset, enable, bank_sel, ready;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_data;
  logic [11:0]       x, y;
  logic              jump, draw, frame_done, active_bank, busy, overrun;

  vector_list_sequencer #(
    .ADDR_W(ADDR_W), .MIN_FRAME_CYCLES(MIN_FRAME),
    .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bank_sel(bank_sel),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .x(x), .y(y), .jump(jump), .draw(draw), .ready(ready),
    .frame_done(frame_done), .active_bank(active_bank), .busy(busy),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read list RAM, two banks of 8 words.
  logic [31:0] mem [16];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int ex; int ey; int cyc; } ev_t;
  ev_t evq[$];
  ev_t exp_ev[$];
  int  fd_cyc[$];
  int  rd_addr[$];
  int  rd_cyc[$];
  int  exp_rd[$];
  int  exp_ovr;
  int  both_err = 0, stab_err = 0, fd_len_err = 0;
  bit  rst_seen = 1, prev_fd = 0;
  logic [11:0] last_x, last_y;

  int  tests = 0, fails = 0;
  bit  rand_ready = 0;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      rst_seen = 1;
      prev_fd  = 0;
    end else begin
      if (rst_seen) begin
        last_x = x; last_y = y; rst_seen = 0;
      end else if (!(jump || draw) && (x != last_x || y != last_y)) stab_err++;
      if (jump && draw) both_err++;
      if (jump || draw) begin
        evq.push_back('{draw ? 1 : 0, int'(x), int'(y), cyc});
        last_x = x; last_y = y;
      end
      if (frame_done) begin
        if (prev_fd) fd_len_err++;
        fd_cyc.push_back(cyc);
      end
      prev_fd = frame_done;
      if (mem_rd) begin
        rd_addr.push_back(int'(mem_addr));
        rd_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input int cx, input int cy);
    logic [11:0] xx, yy;
    xx = 12'(cx);
    yy = 12'(cy);
    return {op, 6'b0, xx, yy};
  endfunction

  function automatic int qsize(input int sel);
    if (sel == 0) return fd_cyc.size();
    if (sel == 1) return evq.size();
    return rd_addr.size();
  endfunction

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (evq[i]) if (evq[i].kind == k) n++;
    return n;
  endfunction

  // Wait for queue sel (0 frame_done, 1 strobes, 2 reads) to reach n entries.
  task automatic wait_q(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while (qsize(sel) < n && k < budget) begin
      @(posedge clk); #1;
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    if (qsize(sel) < n) check({tag, "_timeout"}, qsize(sel), n);
  endtask

  task automatic clear_q();
    evq.delete(); fd_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1; enable = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    clear_q();
  endtask

  // Reference model: walk the bank's list as the frame should.
  task automatic model_frame(input int bank);
    logic [31:0] w;
    exp_ev.delete(); exp_rd.delete(); exp_ovr = 0;
    for (int i = 0; i < 8; i++) begin
      w = mem[bank * 8 + i];
      exp_rd.push_back(bank * 8 + i);
      if (w[31:30] == 2'b10) return;
      if (w[31:30] != 2'b11) exp_ev.push_back('{int'(w[31:30]), int'(w[23:12]), int'(w[11:0]), 0});
    end
    exp_ovr = 1;
  endtask

  task automatic check_frame(input string tag);
    int bad;
    check({tag, "_nstrobes"}, evq.size(), exp_ev.size());
    bad = 0;
    for (int i = 0; i < evq.size() && i < exp_ev.size(); i++)
      if (evq[i].kind != exp_ev[i].kind || evq[i].ex != exp_ev[i].ex || evq[i].ey != exp_ev[i].ey) bad++;
    check({tag, "_strobe_data_errs"}, bad, 0);
    check({tag, "_nreads"}, rd_addr.size(), exp_rd.size());
    bad = 0;
    for (int i = 0; i < rd_addr.size() && i < exp_rd.size(); i++)
      if (rd_addr[i] != exp_rd[i]) bad++;
    check({tag, "_addr_errs"}, bad, 0);
    check({tag, "_overrun"}, overrun, exp_ovr);
  endtask

  task automatic load(input int bank, input logic [31:0] w [8]);
    for (int i = 0; i < 8; i++) mem[bank * 8 + i] = w[i];
  endtask

  typedef struct {
    logic [31:0] w [8];
    int n_jump; int n_draw; int last_x; int last_y; int ovr;
  } vec_t;

  vec_t tbl[5];
  logic [31:0] allend [8];
  logic [31:0] prog [8];

  initial begin
    reset = 1; enable = 0; bank_sel = 0; ready = 1;
    for (int i = 0; i < 8; i++) allend[i] = E_CMD;

    tbl[0].w = '{mk(0,100,200), mk(1,300,400), E_CMD, E_CMD, E_CMD, E_CMD, E_CMD, E_CMD};
    tbl[0].n_jump = 1; tbl[0].n_draw = 1; tbl[0].last_x = 300; tbl[0].last_y = 400; tbl[0].ovr = 0;
    tbl[1].w = '{N_CMD, N_CMD, mk(1,4095,0), E_CMD, E_CMD, E_CMD, E_CMD, E_CMD};
    tbl[1].n_jump = 0; tbl[1].n_draw = 1; tbl[1].last_x = 4095; tbl[1].last_y = 0; tbl[1].ovr = 0;
    tbl[2].w = '{mk(1,1,4095), mk(1,11,4094), mk(1,21,4093), mk(1,31,4092),
                 mk(1,41,4091), mk(1,51,4090), mk(1,61,4089), mk(1,71,4088)};
    tbl[2].n_jump = 0; tbl[2].n_draw = 8; tbl[2].last_x = 71; tbl[2].last_y = 4088; tbl[2].ovr = 1;
    tbl[3].w = allend;
    tbl[3].n_jump = 0; tbl[3].n_draw = 0; tbl[3].last_x = 0; tbl[3].last_y = 0; tbl[3].ovr = 0;
    tbl[4].w = '{mk(0,4095,4095), N_CMD, mk(0,0,0), mk(1,2048,1), E_CMD, E_CMD, E_CMD, E_CMD};
    tbl[4].n_jump = 2; tbl[4].n_draw = 1; tbl[4].last_x = 2048; tbl[4].last_y = 1; tbl[4].ovr = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {busy, jump, draw, frame_done, active_bank, overrun, mem_rd, mem_addr, x, y}, 0);

    // Table-driven lists, ready tied high
    for (int r = 0; r < 5; r++) begin
      load(0, tbl[r].w); load(1, allend);
      do_reset();
      bank_sel = 0; ready = 1; enable = 1;
      wait_q(0, 1, 400, $sformatf("tbl%0d", r));
      model_frame(0);
      check($sformatf("tbl%0d_jumps", r), count_kind(0), tbl[r].n_jump);
      check($sformatf("tbl%0d_draws", r), count_kind(1), tbl[r].n_draw);
      check($sformatf("tbl%0d_x", r), x, tbl[r].last_x);
      check($sformatf("tbl%0d_y", r), y, tbl[r].last_y);
      check($sformatf("tbl%0d_ovr", r), overrun, tbl[r].ovr);
      check_frame($sformatf("tbl%0d_model", r));
    end

    // Timing: strobe spacing and minimum frame period
    load(0, tbl[0].w);
    do_reset();
    bank_sel = 0; ready = 1; enable = 1;
    wait_q(0, 2, 400, "period");
    check("period_nstrobes", evq.size(), 4);
    if (evq.size() >= 2) begin
      check("period_jump", {evq[0].kind, evq[0].ex, evq[0].ey}, {32'd0, 32'd100, 32'd200});
      check("period_draw", {evq[1].kind, evq[1].ex, evq[1].ey}, {32'd1, 32'd300, 32'd400});
      check("period_gap_ok", (evq[1].cyc - evq[0].cyc) >= SETTLE + 3, 1);
    end
    check("period_nreads", rd_addr.size(), 6);
    if (rd_cyc.size() >= 4) check("period_fetch_to_fetch", rd_cyc[3] - rd_cyc[0], MIN_FRAME);
    if (fd_cyc.size() >= 2) check("period_done_to_done", fd_cyc[1] - fd_cyc[0], MIN_FRAME);
    enable = 0;

    // Ready held low after the jump
    do_reset();
    ready = 1; enable = 1;
    wait_q(1, 1, 100, "stall_jump");
    ready = 0;
    repeat (20) begin @(posedge clk); #1; end
    check("stall_no_early_draw", evq.size(), 1);
    ready = 1;
    begin
      int r_cyc;
      r_cyc = cyc;
      wait_q(0, 1, 200, "stall");
      check("stall_nstrobes", evq.size(), 2);
      if (evq.size() >= 2) check("stall_draw_cycle", evq[1].cyc, r_cyc + 1);
    end
    enable = 0;

    // Bank switch only at the frame boundary
    load(0, allend);
    prog = '{mk(0,1,1), E_CMD, E_CMD, E_CMD, E_CMD, E_CMD, E_CMD, E_CMD};
    load(1, prog);
    do_reset();
    bank_sel = 0; ready = 1; enable = 1;
    wait_q(2, 1, 50, "bank_first");
    bank_sel = 1;
    wait_q(0, 1, 100, "bank_end");
    check("bank_active_old", active_bank, 0);
    check("bank_reads_old", rd_addr.size(), 1);
    wait_q(2, 2, 200, "bank_next");
    check("bank_active_new", active_bank, 1);
    if (rd_addr.size() >= 2) begin
      check("bank_new_addr", rd_addr[1], 8);
      check("bank_restart_cycle", rd_cyc[1] - rd_cyc[0], MIN_FRAME);
    end
    wait_q(1, 1, 50, "bank_jump");
    if (evq.size() >= 1) check("bank_jump", {evq[0].kind, evq[0].ex, evq[0].ey}, {32'd0, 32'd1, 32'd1});
    enable = 0;

    // Overrun is sticky and the next frame starts at word 0
    load(0, tbl[2].w); load(1, allend);
    do_reset();
    bank_sel = 0; ready = 1; enable = 1;
    wait_q(0, 1, 400, "ovr_first");
    check("ovr_set", overrun, 1);
    wait_q(2, 9, 200, "ovr_restart");
    if (rd_addr.size() >= 9) check("ovr_restart_addr", rd_addr[8], 0);
    check("ovr_sticky_mid", overrun, 1);
    wait_q(0, 2, 400, "ovr_second");
    check("ovr_sticky_end", overrun, 1);
    check("ovr_ndraws", count_kind(1), 16);
    enable = 0;

    // Reset during SETTLE of the second command
    prog = '{mk(0,100,200), mk(1,300,400), mk(1,500,600), E_CMD, E_CMD, E_CMD, E_CMD, E_CMD};
    load(0, allend); load(1, prog);
    do_reset();
    bank_sel = 1; ready = 1; enable = 1;
    wait_q(1, 2, 200, "rst_mid");
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs",
          {busy, jump, draw, frame_done, active_bank, overrun, mem_rd, mem_addr, x, y}, 0);
    @(posedge clk); #1;
    reset = 0;
    clear_q();
    wait_q(0, 1, 300, "rst_restart");
    model_frame(1);
    check_frame("rst_restart");
    if (rd_addr.size() >= 1) check("rst_restart_addr", rd_addr[0], 8);
    enable = 0;

    // Random lists with random ready
    for (int it = 0; it < 25; it++) begin
      int b;
      logic [1:0] op;
      b = $urandom_range(0, 1);
      for (int i = 0; i < 16; i++) mem[i] = E_CMD;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 9) == 0) op = 2'b10;
        else begin
          op = 2'($urandom_range(0, 2));
          if (op == 2'b10) op = 2'b11;
        end
        mem[b * 8 + i] = {op, 6'($urandom), 12'($urandom), 12'($urandom)};
      end
      do_reset();
      bank_sel = b[0]; ready = 1; enable = 1; rand_ready = 1;
      wait_q(0, 1, 3000, $sformatf("rnd%0d", it));
      rand_ready = 0; ready = 1;
      model_frame(b);
      check_frame($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_bank", it), active_bank, b);
      enable = 0;
    end

    check("never_both_strobes", both_err, 0);
    check("xy_held_between_strobes", stab_err, 0);
    check("frame_done_one_cycle", fd_len_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
